target_debug_responder: RTL and testbench
=========================================

Name: target_debug_responder

Overview:
- Target-side end of the supervisor debug interface; the visor MCU drives it through its bus_ctrl, tg_force, force_opcode and bp0..bp3_addr registers.
- Compares the target fetch address against 4 breakpoints, stalls the target on a hit and captures the halted exr into exr_shadow.
- Injects visor-supplied opcodes into the target exr, pulses single forced executions and latches debug_peek_reg writes for readback.
- Sits between the target core's fetch/exr logic and the visor register file.

Parameters:
BP_DISABLE, 16'hffff, breakpoint address value meaning "disabled"; never matches.
NUM_BP, 4, breakpoint count; fixed at 4 in this revision.

Ports:
clk  in  1  system clock (single clock domain)
reset  in  1  asynchronous active-high reset
bp_we  in  4  one-hot write strobe for bp0..bp3_addr (visor write cycle)
bp_wdata  in  16  breakpoint address write data
bus_ctrl  in  3  bit1 tg_reset, bit2 divert_code_bus; bit0 reserved
tg_force  in  3  bit0 hold_state, bit1 force_load_exr, bit2 force_exec
force_opcode  in  16  opcode to inject into target exr
tg_fetch_addr  in  16  target fetch address
tg_fetch_valid  in  1  target loads exr from tg_fetch_addr this cycle if tg_run_en
tg_exr_value  in  16  target's current exr contents
tg_peek_we  in  1  target executing debug_peek_reg write
tg_peek_data  in  16  value written to debug_peek_reg
tg_run_en  out  1  target advance enable (combinational)
tg_reset_out  out  1  target reset request (registered)
tg_code_divert  out  1  target code mux selects force_opcode (registered)
tg_exr_force_load  out  1  1-cycle pulse: load force_opcode into exr
tg_exr_force_exec  out  1  1-cycle pulse: execute exr once
bp_addr  out  64  {bp3,bp2,bp1,bp0} readback
bp_status  out  16  [3:0] hit flags, [4] halted, [15:5] zero
exr_shadow  out  16  exr captured at halt
peek_data  out  16  last debug_peek_reg value

Behaviour:
- Async reset: bp regs = BP_DISABLE; skip[3:0]=0; state RUN; bp_status, exr_shadow, peek_data = 0; tg_reset_out=1; tg_code_divert=0; force pulses 0; edge-detect history = 0.
- bp regs: bp_we[n] loads bp_wdata next edge; multiple strobes load all selected regs.
- tg_reset_out, tg_code_divert = bus_ctrl bits 1 and 2, registered (1-cycle latency).
- match[n] = tg_fetch_valid & (tg_fetch_addr == bp[n]) & (bp[n] != BP_DISABLE) & !skip[n].
- tg_run_en = (state==RUN) & !tg_force[0] & !tg_reset_out & !(|match); the matching fetch is blocked in the same cycle.
- States:
  - RESET_HOLD: entered while tg_reset_out=1; clears bp_status and skip; moves to RUN when tg_reset_out=0.
  - RUN: on |match with tg_force[0]=0 and tg_reset_out=0 -> HALTED next edge; bp_status[3:0] |= match; exr_shadow <= tg_exr_value.
  - HALTED: bp_status[4]=1. Any bp_we (even an unchanged value) -> RUN next edge; bp_status[4:0] cleared; skip[n] set for every n with bp_status[n]=1.
- skip[n] clears when tg_fetch_valid & tg_run_en & tg_fetch_addr != bp[n]. The target passes the hit breakpoint exactly once; the next fetch of that address halts again.
- hold_state stalls in any state but does not change state. Matches under hold are ignored.
- Force pulses:
  - tg_exr_force_load = rising edge of tg_force[1]; tg_exr_force_exec = rising edge of tg_force[2]; each 1 cycle, registered.
  - Generated only when state==HALTED or tg_force[0]=1; otherwise suppressed.
  - A simultaneous rise of both bits gives load and exec in the same cycle; the target orders load before exec.
- peek_data <= tg_peek_data on tg_peek_we in any state, including forced exec.
- bus_ctrl tg_reset mid-halt: enter RESET_HOLD; halt, status and skip are cleared; bp regs retained.
- Reset during a forced sequence: all pulses drop immediately (async).

Test Plan:
- Reset then bus_ctrl=0: bp regs read 0xffff, tg_reset_out 1->0 one cycle after bus_ctrl write, tg_run_en=1, bp_status=0.
- bp0=0x0015, target fetches 0x0015: tg_run_en=0 same cycle; next cycle bp_status=0x0011, exr_shadow = tg_exr_value.
- While halted: bus_ctrl=4, tg_force=1, force_opcode=0x7c07, tg_force=3, 5, 1; target writes peek 0x1234 -> one load pulse, one exec pulse, peek_data=0x1234, tg_code_divert=1.
- Write bp0=0x0015 while halted: RUN, bp_status=0, fetch at 0x0015 proceeds, fetch at 0x0016 clears skip, next fetch 0x0015 halts again.
- bp0=bp2=0x0020 both hit: bp_status=0x0015. Setting bp1=BP_DISABLE never matches at 0xffff.
- Halted, bus_ctrl=2: RESET_HOLD, bp_status=0, bp regs unchanged. tg_force=2 while RUN and hold=0: no force pulse.

Source files
------------

// File: rtl/target_debug_responder_if.sv
// rtl/target_debug_responder_if.sv - visor register and target fetch/exr bundle for the debug responder
interface target_debug_responder_if;
    logic [3:0]  bp_we;
    logic [15:0] bp_wdata;
    logic [2:0]  bus_ctrl;
    logic [2:0]  tg_force;
    logic [15:0] force_opcode;
    logic [15:0] tg_fetch_addr;
    logic        tg_fetch_valid;
    logic [15:0] tg_exr_value;
    logic        tg_peek_we;
    logic [15:0] tg_peek_data;
    logic        tg_run_en;
    logic        tg_reset_out;
    logic        tg_code_divert;
    logic        tg_exr_force_load;
    logic        tg_exr_force_exec;
    logic [63:0] bp_addr;
    logic [15:0] bp_status;
    logic [15:0] exr_shadow;
    logic [15:0] peek_data;

    modport slave (
        input  bp_we, bp_wdata, bus_ctrl, tg_force, force_opcode,
        input  tg_fetch_addr, tg_fetch_valid, tg_exr_value, tg_peek_we, tg_peek_data,
        output tg_run_en, tg_reset_out, tg_code_divert, tg_exr_force_load, tg_exr_force_exec,
        output bp_addr, bp_status, exr_shadow, peek_data
    );

    modport master (
        output bp_we, bp_wdata, bus_ctrl, tg_force, force_opcode,
        output tg_fetch_addr, tg_fetch_valid, tg_exr_value, tg_peek_we, tg_peek_data,
        input  tg_run_en, tg_reset_out, tg_code_divert, tg_exr_force_load, tg_exr_force_exec,
        input  bp_addr, bp_status, exr_shadow, peek_data
    );
endinterface

// File: rtl/target_debug_responder.sv
// rtl/target_debug_responder.sv - breakpoint halt, opcode injection and peek capture for the target core
module target_debug_responder #(
    parameter logic [15:0] BP_DISABLE = 16'hffff,
    parameter int          NUM_BP     = 4
) (
    input logic                   clk,
    input logic                   reset,
    target_debug_responder_if.slave dbg
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HALTED     = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [15:0]         bp [NUM_BP];
    logic [NUM_BP-1:0]   skip, skip_next;
    logic [NUM_BP-1:0]   match;
    logic [4:0]          status, status_next;
    logic                capture;
    logic [1:0]          force_hist;
    logic                force_ok;
    logic                hold;
    logic                unused_bus_bit;

    assign unused_bus_bit = dbg.bus_ctrl[0];
    assign hold           = dbg.tg_force[0];

    always_comb begin
        match = '0;
        for (int n = 0; n < NUM_BP; n++) begin
            match[n] = dbg.tg_fetch_valid && (dbg.tg_fetch_addr == bp[n]) &&
                       (bp[n] != BP_DISABLE) && !skip[n];
        end
    end

    // The matching fetch itself must be blocked, so run enable is purely combinational.
    assign dbg.tg_run_en = (state == RUN) && !hold && !dbg.tg_reset_out && !(|match);

    always_comb begin
        state_next  = state;
        status_next = status;
        skip_next   = skip;
        capture     = 1'b0;
        for (int n = 0; n < NUM_BP; n++) begin
            if (dbg.tg_fetch_valid && dbg.tg_run_en && (dbg.tg_fetch_addr != bp[n]))
                skip_next[n] = 1'b0;
        end
        case (state)
            RESET_HOLD: begin
                status_next = '0;
                skip_next   = '0;
                if (!dbg.tg_reset_out)
                    state_next = RUN;
            end
            RUN: begin
                if (dbg.tg_reset_out) begin
                    state_next = RESET_HOLD;
                end else if ((|match) && !hold) begin
                    state_next       = HALTED;
                    status_next[3:0] = status[3:0] | match;
                    status_next[4]   = 1'b1;
                    capture          = 1'b1;
                end
            end
            HALTED: begin
                if (dbg.tg_reset_out) begin
                    state_next  = RESET_HOLD;
                    status_next = '0;
                    skip_next   = '0;
                end else if (|dbg.bp_we) begin
                    // Resuming lets each hit breakpoint pass exactly once.
                    state_next  = RUN;
                    status_next = '0;
                    skip_next   = skip_next | status[NUM_BP-1:0];
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            status <= '0;
            skip   <= '0;
        end else begin
            state  <= state_next;
            status <= status_next;
            skip   <= skip_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NUM_BP; n++)
                bp[n] <= BP_DISABLE;
        end else begin
            for (int n = 0; n < NUM_BP; n++)
                if (dbg.bp_we[n])
                    bp[n] <= dbg.bp_wdata;
        end
    end

    assign force_ok = (state == HALTED) || hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg.tg_reset_out      <= 1'b1;
            dbg.tg_code_divert    <= 1'b0;
            dbg.tg_exr_force_load <= 1'b0;
            dbg.tg_exr_force_exec <= 1'b0;
            force_hist            <= '0;
            dbg.exr_shadow        <= '0;
            dbg.peek_data         <= '0;
        end else begin
            dbg.tg_reset_out      <= dbg.bus_ctrl[1];
            dbg.tg_code_divert    <= dbg.bus_ctrl[2];
            dbg.tg_exr_force_load <= dbg.tg_force[1] && !force_hist[0] && force_ok;
            dbg.tg_exr_force_exec <= dbg.tg_force[2] && !force_hist[1] && force_ok;
            force_hist            <= dbg.tg_force[2:1];
            if (capture)
                dbg.exr_shadow <= dbg.tg_exr_value;
            if (dbg.tg_peek_we)
                dbg.peek_data <= dbg.tg_peek_data;
        end
    end

    always_comb begin
        dbg.bp_addr = '0;
        for (int n = 0; n < NUM_BP; n++)
            dbg.bp_addr[16*n +: 16] = bp[n];
    end

    assign dbg.bp_status = {11'd0, status};

endmodule

// File: tb/tb_target_debug_responder.sv
// tb/tb_target_debug_responder.sv - directed self-checking bench for target_debug_responder
module tb_target_debug_responder;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    target_debug_responder_if dbg ();

    target_debug_responder dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bp(input logic [3:0] we, input logic [15:0] data);
        dbg.bp_we    = we;
        dbg.bp_wdata = data;
        step();
        dbg.bp_we    = 4'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset              = 1'b1;
        dbg.bp_we          = 4'd0;
        dbg.bp_wdata       = 16'd0;
        dbg.bus_ctrl       = 3'd0;
        dbg.tg_force       = 3'd0;
        dbg.force_opcode   = 16'd0;
        dbg.tg_fetch_addr  = 16'd0;
        dbg.tg_fetch_valid = 1'b0;
        dbg.tg_exr_value   = 16'd0;
        dbg.tg_peek_we     = 1'b0;
        dbg.tg_peek_data   = 16'd0;
        #12;
        check("rst_reset_out", dbg.tg_reset_out, 1);
        check("rst_bp_addr", dbg.bp_addr, 64'hffff_ffff_ffff_ffff);
        check("rst_status", dbg.bp_status, 0);
        check("rst_run_en", dbg.tg_run_en, 0);
        reset = 1'b0;
        step();
        check("reset_out_low", dbg.tg_reset_out, 0);
        step();
        check("run_en_up", dbg.tg_run_en, 1);
        check("status_run", dbg.bp_status, 0);

        // first breakpoint hit
        write_bp(4'b0001, 16'h0015);
        check("bp0_written", dbg.bp_addr, 64'hffff_ffff_ffff_0015);
        dbg.tg_fetch_addr  = 16'h0015;
        dbg.tg_fetch_valid = 1'b1;
        dbg.tg_exr_value   = 16'habcd;
        #1;
        check("hit_blocks", dbg.tg_run_en, 0);
        step();
        dbg.tg_fetch_valid = 1'b0;
        check("hit_status", dbg.bp_status, 16'h0011);
        check("hit_shadow", dbg.exr_shadow, 16'habcd);

        // opcode injection while halted
        dbg.bus_ctrl     = 3'd4;
        dbg.tg_force     = 3'd1;
        dbg.force_opcode = 16'h7c07;
        step();
        check("divert", dbg.tg_code_divert, 1);
        check("no_pulse_idle", {dbg.tg_exr_force_load, dbg.tg_exr_force_exec}, 2'b00);
        dbg.tg_force = 3'd3;
        step();
        check("load_pulse", {dbg.tg_exr_force_load, dbg.tg_exr_force_exec}, 2'b10);
        dbg.tg_force = 3'd5;
        step();
        check("exec_pulse", {dbg.tg_exr_force_load, dbg.tg_exr_force_exec}, 2'b01);
        dbg.tg_force     = 3'd1;
        dbg.tg_peek_we   = 1'b1;
        dbg.tg_peek_data = 16'h1234;
        step();
        check("pulses_drop", {dbg.tg_exr_force_load, dbg.tg_exr_force_exec}, 2'b00);
        check("peek", dbg.peek_data, 16'h1234);
        dbg.tg_peek_we = 1'b0;
        dbg.tg_force   = 3'd0;
        dbg.bus_ctrl   = 3'd0;
        step();
        check("still_halted", dbg.bp_status, 16'h0011);
        check("halted_run_en", dbg.tg_run_en, 0);

        // resume, skip once, re-arm
        write_bp(4'b0001, 16'h0015);
        check("resume_status", dbg.bp_status, 0);
        dbg.tg_fetch_addr  = 16'h0015;
        dbg.tg_fetch_valid = 1'b1;
        #1;
        check("skip_passes", dbg.tg_run_en, 1);
        step();
        dbg.tg_fetch_addr = 16'h0016;
        #1;
        check("fetch_0016", dbg.tg_run_en, 1);
        step();
        dbg.tg_fetch_addr = 16'h0015;
        #1;
        check("rearm_blocks", dbg.tg_run_en, 0);
        step();
        dbg.tg_fetch_valid = 1'b0;
        check("rearm_status", dbg.bp_status, 16'h0011);

        // two breakpoints on the same address
        write_bp(4'b0101, 16'h0020);
        check("bp02_written", dbg.bp_addr, 64'hffff_0020_ffff_0020);
        dbg.tg_fetch_addr  = 16'h0030;
        dbg.tg_fetch_valid = 1'b1;
        step();
        dbg.tg_fetch_addr = 16'h0020;
        step();
        dbg.tg_fetch_valid = 1'b0;
        check("dual_status", dbg.bp_status, 16'h0015);

        // disabled breakpoint never matches 0xffff
        write_bp(4'b0010, 16'hffff);
        dbg.tg_fetch_addr  = 16'hffff;
        dbg.tg_fetch_valid = 1'b1;
        #1;
        check("disabled_run", dbg.tg_run_en, 1);
        step();
        dbg.tg_fetch_valid = 1'b0;
        check("disabled_status", dbg.bp_status, 0);

        // hold ignores matches but still permits force pulses
        dbg.tg_force       = 3'd1;
        dbg.tg_fetch_addr  = 16'h0020;
        dbg.tg_fetch_valid = 1'b1;
        step();
        check("hold_no_halt", dbg.bp_status, 0);
        dbg.tg_fetch_valid = 1'b0;
        dbg.tg_force       = 3'd3;
        step();
        check("hold_load", dbg.tg_exr_force_load, 1);
        dbg.tg_force = 3'd0;
        step();

        // tg_reset mid-halt
        dbg.tg_fetch_addr  = 16'h0020;
        dbg.tg_fetch_valid = 1'b1;
        step();
        dbg.tg_fetch_valid = 1'b0;
        check("halt_again", dbg.bp_status, 16'h0015);
        dbg.bus_ctrl = 3'd2;
        step();
        check("reset_req", dbg.tg_reset_out, 1);
        step();
        check("hold_status", dbg.bp_status, 0);
        check("bp_retained", dbg.bp_addr, 64'hffff_0020_ffff_0020);
        dbg.bus_ctrl = 3'd0;
        step();
        step();
        check("back_run", dbg.tg_run_en, 1);

        // force rise in RUN without hold is suppressed
        dbg.tg_force = 3'd2;
        step();
        check("run_no_pulse", dbg.tg_exr_force_load, 0);
        dbg.tg_force = 3'd0;
        step();

        // async reset kills an active exec pulse
        dbg.tg_force = 3'd1;
        step();
        dbg.tg_force = 3'd5;
        step();
        check("exec_under_hold", dbg.tg_exr_force_exec, 1);
        reset = 1'b1;
        #1;
        check("async_drop", dbg.tg_exr_force_exec, 0);
        check("async_bp", dbg.bp_addr, 64'hffff_ffff_ffff_ffff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
